// File: rtl/card_dealer.sv
// Card dealer: a 52-card deck dealt without replacement. A free-running LFSR
// picks a start index, then a linear probe walks forward to the next undealt card.
`timescale 1ns/1ps
module card_dealer (
    input  logic       Clock,
    input  logic       reset_n,
    input  logic       draw_req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [4:0] card_val,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic       busy,
    output logic       draw_err,
    output logic [5:0] cards_left
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEEK = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_lfsr;
    logic [51:0] r_used;
    logic [5:0]  r_idx;
    logic [5:0]  r_cards_left;
    logic        r_card_valid;
    logic        r_draw_err;
    logic [4:0]  r_card_val;
    logic [3:0]  r_card_rank;
    logic [1:0]  r_card_suit;

    state_t      w_state_nxt;
    logic [51:0] w_used_nxt;
    logic [5:0]  w_idx_nxt;
    logic [5:0]  w_cards_left_nxt;
    logic        w_card_valid_nxt;
    logic        w_draw_err_nxt;
    logic [4:0]  w_card_val_nxt;
    logic [3:0]  w_card_rank_nxt;
    logic [1:0]  w_card_suit_nxt;
    logic [5:0]  w_lfsr_idx;
    logic [3:0]  w_probe_rank;

    function automatic logic [1:0] suit_of(input logic [5:0] idx);
        logic [1:0] s;
        if (idx >= 6'd39)      s = 2'd3;
        else if (idx >= 6'd26) s = 2'd2;
        else if (idx >= 6'd13) s = 2'd1;
        else                   s = 2'd0;
        return s;
    endfunction

    function automatic logic [3:0] rank_of(input logic [5:0] idx);
        logic [5:0] t;
        if (idx >= 6'd39)      t = idx - 6'd39;
        else if (idx >= 6'd26) t = idx - 6'd26;
        else if (idx >= 6'd13) t = idx - 6'd13;
        else                   t = idx;
        return t[3:0];
    endfunction

    // Face cards count 10, the ace counts 1.
    function automatic logic [4:0] value_of(input logic [3:0] rank);
        logic [4:0] v;
        if (rank == 4'd0)      v = 5'd1;
        else if (rank <= 4'd9) v = {1'b0, rank} + 5'd1;
        else                   v = 5'd10;
        return v;
    endfunction

    assign w_lfsr_idx   = (r_lfsr < 6'd52) ? r_lfsr : (r_lfsr - 6'd52);
    assign w_probe_rank = rank_of(r_idx);

    // Next-state, deck-mask and output-register values.
    always_comb begin
        w_state_nxt      = r_state;
        w_used_nxt       = r_used;
        w_idx_nxt        = r_idx;
        w_cards_left_nxt = r_cards_left;
        w_card_valid_nxt = 1'b0;
        w_draw_err_nxt   = 1'b0;
        w_card_val_nxt   = r_card_val;
        w_card_rank_nxt  = r_card_rank;
        w_card_suit_nxt  = r_card_suit;
        case (r_state)
            ST_IDLE: begin
                if (shuffle) begin
                    w_used_nxt       = 52'd0;
                    w_cards_left_nxt = 6'd52;
                end else if (draw_req) begin
                    if (r_cards_left == 6'd0) begin
                        w_draw_err_nxt = 1'b1;
                    end else begin
                        w_idx_nxt   = w_lfsr_idx;
                        w_state_nxt = ST_SEEK;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEEK: begin
                // A shuffle aborts the search even if this probe would have hit.
                if (shuffle) begin
                    w_used_nxt       = 52'd0;
                    w_cards_left_nxt = 6'd52;
                    w_state_nxt      = ST_IDLE;
                end else if (!r_used[r_idx]) begin
                    w_used_nxt       = r_used | (52'd1 << r_idx);
                    w_cards_left_nxt = r_cards_left - 6'd1;
                    w_card_valid_nxt = 1'b1;
                    w_card_rank_nxt  = w_probe_rank;
                    w_card_suit_nxt  = suit_of(r_idx);
                    w_card_val_nxt   = value_of(w_probe_rank);
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_idx_nxt = (r_idx == 6'd51) ? 6'd0 : (r_idx + 6'd1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Free-running LFSR, deck bookkeeping and registered outputs.
    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr       <= 6'd1;
            r_used       <= 52'd0;
            r_idx        <= 6'd0;
            r_cards_left <= 6'd52;
            r_card_valid <= 1'b0;
            r_draw_err   <= 1'b0;
            r_card_val   <= 5'd0;
            r_card_rank  <= 4'd0;
            r_card_suit  <= 2'd0;
        end else begin
            r_lfsr       <= {r_lfsr[4:0], r_lfsr[5] ^ r_lfsr[4]};
            r_used       <= w_used_nxt;
            r_idx        <= w_idx_nxt;
            r_cards_left <= w_cards_left_nxt;
            r_card_valid <= w_card_valid_nxt;
            r_draw_err   <= w_draw_err_nxt;
            r_card_val   <= w_card_val_nxt;
            r_card_rank  <= w_card_rank_nxt;
            r_card_suit  <= w_card_suit_nxt;
        end
    end

    assign card_valid = r_card_valid;
    assign card_val   = r_card_val;
    assign card_rank  = r_card_rank;
    assign card_suit  = r_card_suit;
    assign busy       = (r_state == ST_SEEK);
    assign draw_err   = r_draw_err;
    assign cards_left = r_cards_left;

endmodule

// File: tb/tb_card_dealer.sv
// Directed self-checking bench for card_dealer: first draw, full deck,
// empty deck, shuffle, shuffle abort and asynchronous reset during a search.
`timescale 1ns/1ps
module tb_card_dealer;

    logic       Clock;
    logic       reset_n;
    logic       draw_req;
    logic       shuffle;
    logic       card_valid;
    logic [4:0] card_val;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic       busy;
    logic       draw_err;
    logic [5:0] cards_left;

    int n_checks = 0;
    int n_fail   = 0;

    card_dealer dut (
        .Clock      (Clock),
        .reset_n    (reset_n),
        .draw_req   (draw_req),
        .shuffle    (shuffle),
        .card_valid (card_valid),
        .card_val   (card_val),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .busy       (busy),
        .draw_err   (draw_err),
        .cards_left (cards_left)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected finish before 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Requests one card and waits (bounded) for card_valid; lat counts edges after the sampling edge.
    task automatic do_draw(output int lat, output bit got);
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        lat = 0;
        got = 1'b0;
        chk("accept_busy", int'(busy), 1);
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            lat++;
            chk("busy_valid_excl", int'(busy & card_valid), 0);
            if (card_valid) got = 1'b1;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, int'(card_valid), 0);
        chk({tag, "_err"},   int'(draw_err),   0);
        chk({tag, "_busy"},  int'(busy),       0);
        chk({tag, "_val"},   int'(card_val),   0);
        chk({tag, "_rank"},  int'(card_rank),  0);
        chk({tag, "_suit"},  int'(card_suit),  0);
        chk({tag, "_left"},  int'(cards_left), 52);
    endtask

    initial begin
        int          lat;
        bit          got;
        logic [51:0] seen;
        int          sum;
        int          key;
        int          exp_val;

        reset_n  = 1'b0;
        draw_req = 1'b0;
        shuffle  = 1'b0;
        #12;
        chk_reset_values("reset");

        // Test 1: first draw with lfsr=1 gives idx 1 -> the 2 of suit 0.
        @(posedge Clock);
        #1;
        reset_n = 1'b1;
        do_draw(lat, got);
        chk("t1_got",  int'(got), 1);
        chk("t1_lat",  lat, 1);
        chk("t1_rank", int'(card_rank), 1);
        chk("t1_val",  int'(card_val), 2);
        chk("t1_suit", int'(card_suit), 0);
        chk("t1_left", int'(cards_left), 51);
        chk("t1_busy", int'(busy), 0);
        tick();
        chk("t1_valid_pulse", int'(card_valid), 0);

        // Test 4: shuffle with a simultaneous draw_req; the draw is discarded.
        shuffle  = 1'b1;
        draw_req = 1'b1;
        tick();
        shuffle  = 1'b0;
        draw_req = 1'b0;
        chk("t4_left",  int'(cards_left), 52);
        chk("t4_valid", int'(card_valid), 0);
        chk("t4_err",   int'(draw_err), 0);
        chk("t4_busy",  int'(busy), 0);

        // Test 2: full deck. lfsr has stepped 1,2,4,8,16 so the first card is idx 16.
        seen = 52'd0;
        sum  = 0;
        for (int k = 0; k < 52; k++) begin
            do_draw(lat, got);
            chk("t2_got", int'(got), 1);
            chk("t2_lat_le_52", int'(lat <= 52), 1);
            if (k == 0) begin
                chk("t2_first_rank", int'(card_rank), 3);
                chk("t2_first_suit", int'(card_suit), 1);
                chk("t2_first_val",  int'(card_val), 4);
            end
            chk("t2_rank_range", int'(card_rank < 4'd13), 1);
            key = int'(card_suit) * 13 + int'(card_rank);
            if (key < 52) begin
                chk("t2_distinct", int'(seen[key]), 0);
                seen[key] = 1'b1;
            end
            exp_val = (card_rank == 4'd0) ? 1 : ((card_rank <= 4'd9) ? int'(card_rank) + 1 : 10);
            chk("t2_val_map", int'(card_val), exp_val);
            chk("t2_left", int'(cards_left), 51 - k);
            sum += int'(card_val);
        end
        chk("t2_sum",  sum, 340);
        chk("t2_all_seen", int'(seen == {52{1'b1}}), 1);
        chk("t2_left_zero", int'(cards_left), 0);

        // Test 3: empty deck.
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        chk("t3_err",   int'(draw_err), 1);
        chk("t3_valid", int'(card_valid), 0);
        chk("t3_busy",  int'(busy), 0);
        chk("t3_left",  int'(cards_left), 0);
        tick();
        chk("t3_err_pulse", int'(draw_err), 0);
        chk("t3_valid2",    int'(card_valid), 0);
        chk("t3_left2",     int'(cards_left), 0);

        // Shuffle then a normal draw.
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        chk("t4b_left", int'(cards_left), 52);
        do_draw(lat, got);
        chk("t4b_got",  int'(got), 1);
        chk("t4b_left2", int'(cards_left), 51);

        // Test 5: deal down to one remaining card, then abort the last search.
        for (int k = 0; k < 50; k++) begin
            do_draw(lat, got);
            chk("t5_got", int'(got), 1);
        end
        chk("t5_left_one", int'(cards_left), 1);
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        chk("t5_busy", int'(busy), 1);
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        chk("t5_busy_drop", int'(busy), 0);
        chk("t5_valid",     int'(card_valid), 0);
        chk("t5_left",      int'(cards_left), 52);
        tick();
        chk("t5_valid_late", int'(card_valid), 0);
        chk("t5_left_hold",  int'(cards_left), 52);

        // Test 6: asynchronous reset in the middle of a search.
        do_draw(lat, got);
        chk("t6_pre_got", int'(got), 1);
        chk("t6_pre_val_nonzero", int'(card_val != 5'd0), 1);
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        chk("t6_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_values("t6_reset");
        @(posedge Clock);
        #1;
        reset_n = 1'b1;
        do_draw(lat, got);
        chk("t6_got",  int'(got), 1);
        chk("t6_lat",  lat, 1);
        chk("t6_rank", int'(card_rank), 1);
        chk("t6_val",  int'(card_val), 2);
        chk("t6_suit", int'(card_suit), 0);
        chk("t6_left", int'(cards_left), 51);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
# card_dealer

Card source for the blackjack game controller. It holds a single 52-card deck and deals cards without replacement. Each request returns one card's blackjack value, rank and suit over a pulse handshake. It replaces the free-running counters as the source of random card values, so no card is dealt twice until the deck is reshuffled.

## Interface
- No parameters. Deck size 52 and 13 ranks per suit are fixed.
- `Clock` in 1: the single system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `draw_req` in 1: request one card. Sampled only in IDLE.
- `shuffle` in 1: return all cards to the deck. Single-cycle pulse.
- `card_valid` out 1: one-cycle pulse; `card_val`, `card_rank` and `card_suit` are valid in that cycle.
- `card_val` out 5: blackjack value, 1..10. Holds its value until the next card is dealt.
- `card_rank` out 4: 0 = Ace, 1..9 = 2..10, 10 = J, 11 = Q, 12 = K.
- `card_suit` out 2: 0..3.
- `busy` out 1: high while searching for a card (SEEK).
- `draw_err` out 1: one-cycle pulse when a draw is requested from an empty deck.
- `cards_left` out 6: undealt cards, 0..52.

## Operation
- **LFSR.** A 6-bit LFSR runs every cycle:
  - update: lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]}.
  - reset value: 6'b000001. It never reaches zero; period 63.
- **Card index.** idx is 0..51. suit = idx/13, rank = idx%13. card_val = 1 for rank 0, rank+1 for ranks 1..9, and 10 for ranks 10..12.
- **Deck mask.** A 52-bit `used` mask marks dealt cards. Reset and shuffle clear it.
- **IDLE state.**
  - shuffle=1: clear `used`, set cards_left=52, stay in IDLE. Any draw_req in the same cycle is discarded.
  - draw_req=1 and cards_left=0: pulse draw_err, stay in IDLE.
  - draw_req=1 and cards_left>0: load idx = lfsr if lfsr<52, else lfsr−52. Go to SEEK.
- **SEEK state** (one probe per cycle):
  - used[idx]=0:
    - set used[idx]=1 and decrement cards_left;
    - register card_val, card_rank and card_suit;
    - pulse card_valid and return to IDLE.
  - used[idx]=1: set idx = (idx==51) ? 0 : idx+1 and stay in SEEK.
  - shuffle=1: abort. Clear `used`, set cards_left=52, go to IDLE, and do not pulse card_valid.
- draw_req is ignored during SEEK and is not queued. The requester issues the next draw_req only after card_valid or draw_err.
- The sum of card_val over a full deck is 340.

## Timing
- **Reset values.** In IDLE:
  - lfsr = 1 and `used` = 0;
  - cards_left = 52;
  - card_valid, draw_err and busy = 0;
  - card_val, card_rank and card_suit = 0.
- **Latency.** Measured from the edge that samples draw_req to the edge that raises card_valid:
  - minimum 1 edge, when the first probe hits a free card;
  - maximum 52 edges, when only one card remains.
- busy is high from the acceptance edge until the edge that raises card_valid. busy and card_valid are never high together.
- draw_err rises on the edge after the sampled request and lasts exactly one cycle.
- cards_left updates on the same edge that raises card_valid.
- Reset is asserted asynchronously in any state, including mid-SEEK. All outputs return to their reset values immediately, with no partial deal.

## Test plan
1. **First draw.** Release reset and assert draw_req for the first edge (lfsr=1). Expect idx=1: card_valid after one edge with rank=1, val=2, suit=0, and cards_left=51.
2. **Full deck.** Issue 52 sequential draws. Expect:
   - 52 card_valid pulses and all 52 (rank, suit) pairs distinct;
   - card_val sum = 340 and cards_left = 0;
   - every draw latency ≤ 52 edges.
3. **Empty deck.** Issue a 53rd draw_req. Expect a draw_err pulse one cycle later, no card_valid, and cards_left still 0.
4. **Shuffle.** Pulse shuffle with a draw_req in the same cycle. Expect cards_left=52, no card_valid and no draw_err. A following draw is dealt normally.
5. **Abort by shuffle.** Deal 51 cards, then draw and pulse shuffle during SEEK. Expect busy to drop on the next edge, no card_valid, and cards_left=52.
6. **Reset mid-operation.** Assert reset_n=0 mid-SEEK. Expect all outputs at reset values immediately, cards_left=52, and test 1's first draw to repeat identically.
